// File: rtl/secure_fw_ram.sv
// Banked, word-addressed firmware RAM with mode-based lockout and hardware zeroisation.
// A clear sweep zeroes one word of every bank per cycle; accesses are served only in IDLE.
module secure_fw_ram #(
   parameter int NUM_BANKS    = 4,
   parameter int BANK_AW      = 8,
   parameter bit CLEAR_ON_APP = 1'b1,
   localparam int ADDR_WIDTH  = BANK_AW + $clog2(NUM_BANKS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fw_app_mode,
   input  logic                  zeroize,
   input  logic                  cs,
   input  logic [3:0]            we,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           write_data,
   output logic [31:0]           read_data,
   output logic                  ready,
   output logic                  busy,
   output logic                  access_violation
);

   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   logic [0:0]         state;
   logic [BANK_AW-1:0] idx;
   logic               app_q;
   logic               rd_valid;
   logic [BANK_W-1:0]  rd_bank;
   logic [BANK_W-1:0]  bank_sel;
   logic [BANK_AW-1:0] word_addr;
   logic               clear_trig;
   logic               accept;
   logic               mem_wr;
   logic               mem_rd;
   logic [31:0]        bank_rdata [NUM_BANKS];
   logic [31:0]        sel_rdata;

   assign word_addr = address[BANK_AW-1:0];

   generate
      if (NUM_BANKS > 1) begin : g_multi
         assign bank_sel  = address[ADDR_WIDTH-1:BANK_AW];
         assign sel_rdata = bank_rdata[rd_bank];
      end else begin : g_single
         assign bank_sel  = '0;
         assign sel_rdata = bank_rdata[0];
      end
   endgenerate

   // A clear trigger in the same cycle as cs takes priority; the request is not accepted.
   assign clear_trig = zeroize | (CLEAR_ON_APP & fw_app_mode & ~app_q);
   assign accept     = (state == ST_IDLE) & cs & ~clear_trig;
   assign mem_wr     = accept & ~fw_app_mode & (we != 4'b0000);
   assign mem_rd     = accept & ~fw_app_mode & (we == 4'b0000);
   assign busy       = (state == ST_CLEAR);

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_CLEAR;
         idx              <= '0;
         app_q            <= 1'b0;
         ready            <= 1'b0;
         access_violation <= 1'b0;
         rd_valid         <= 1'b0;
         rd_bank          <= '0;
      end else begin
         app_q            <= fw_app_mode;
         ready            <= accept;
         access_violation <= accept & fw_app_mode;
         rd_valid         <= mem_rd;
         if (mem_rd) begin
            rd_bank <= bank_sel;
         end
         case (state)
            ST_CLEAR: begin
               idx <= idx + 1'b1;
               if (idx == '1) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (clear_trig) begin
                  state <= ST_CLEAR;
                  idx   <= '0;
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

   generate
      for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
         logic [31:0] mem [2**BANK_AW];
         logic [31:0] rdata;
         logic        sel;

         assign sel = (bank_sel == BANK_W'(b));

         always_ff @(posedge clk) begin
            if (busy) begin
               mem[idx] <= '0;
            end else if (mem_wr && sel) begin
               for (int i = 0; i < 4; i++) begin
                  if (we[i]) begin
                     mem[word_addr][8*i +: 8] <= write_data[8*i +: 8];
                  end
               end
            end
            if (mem_rd && sel) begin
               rdata <= mem[word_addr];
            end
         end

         assign bank_rdata[b] = rdata;
      end
   endgenerate

   // Gated so stale bank output never appears on the bus outside a completed read.
   assign read_data = rd_valid ? sel_rdata : 32'h0;

endmodule

// File: tb/tb_secure_fw_ram.sv
// Self-checking bench for secure_fw_ram: four configurations driven side by side,
// each checked against a word-array reference model.
module tb_secure_fw_ram;

   localparam int ND = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [ND-1:0]       rst;
   logic [ND-1:0]       app;
   logic [ND-1:0]       zer;
   logic [ND-1:0]       cs;
   logic [ND-1:0][3:0]  we;
   logic [ND-1:0][9:0]  addr;
   logic [ND-1:0][31:0] wd;
   logic [ND-1:0][31:0] rd;
   logic [ND-1:0]       rdy;
   logic [ND-1:0]       bsy;
   logic [ND-1:0]       av;

   logic [31:0] mdl [ND][1024];
   int n_cmp = 0;
   int n_bad = 0;

   // d0: 4x256 clear-on-app, d1: 4x256 no clear-on-app, d2: 2x512, d3: 1x256
   secure_fw_ram #(.NUM_BANKS(4), .BANK_AW(8), .CLEAR_ON_APP(1'b1)) dut0 (
      .clk(clk), .reset(rst[0]), .fw_app_mode(app[0]), .zeroize(zer[0]), .cs(cs[0]),
      .we(we[0]), .address(addr[0]), .write_data(wd[0]), .read_data(rd[0]),
      .ready(rdy[0]), .busy(bsy[0]), .access_violation(av[0]));
   secure_fw_ram #(.NUM_BANKS(4), .BANK_AW(8), .CLEAR_ON_APP(1'b0)) dut1 (
      .clk(clk), .reset(rst[1]), .fw_app_mode(app[1]), .zeroize(zer[1]), .cs(cs[1]),
      .we(we[1]), .address(addr[1]), .write_data(wd[1]), .read_data(rd[1]),
      .ready(rdy[1]), .busy(bsy[1]), .access_violation(av[1]));
   secure_fw_ram #(.NUM_BANKS(2), .BANK_AW(9), .CLEAR_ON_APP(1'b1)) dut2 (
      .clk(clk), .reset(rst[2]), .fw_app_mode(app[2]), .zeroize(zer[2]), .cs(cs[2]),
      .we(we[2]), .address(addr[2]), .write_data(wd[2]), .read_data(rd[2]),
      .ready(rdy[2]), .busy(bsy[2]), .access_violation(av[2]));
   secure_fw_ram #(.NUM_BANKS(1), .BANK_AW(8), .CLEAR_ON_APP(1'b1)) dut3 (
      .clk(clk), .reset(rst[3]), .fw_app_mode(app[3]), .zeroize(zer[3]), .cs(cs[3]),
      .we(we[3]), .address(addr[3][7:0]), .write_data(wd[3]), .read_data(rd[3]),
      .ready(rdy[3]), .busy(bsy[3]), .access_violation(av[3]));

   function automatic int baw(input int d);
      return (d == 2) ? 9 : 8;
   endfunction

   function automatic int asz(input int d);
      return (d == 3) ? 256 : 1024;
   endfunction

   task automatic mdl_clear(input int d);
      for (int i = 0; i < 1024; i++) mdl[d][i] = 32'h0;
   endtask

   task automatic mdl_write(input int d, input logic [9:0] a, input logic [3:0] w,
                            input logic [31:0] data);
      for (int b = 0; b < 4; b++)
         if (w[b]) mdl[d][a][8*b +: 8] = data[8*b +: 8];
   endtask

   // One isolated access: request for one cycle, sample the response after the edge.
   task automatic do_access(input int d, input logic [3:0] w, input logic [9:0] a,
                            input logic [31:0] data, input logic m,
                            output logic r, output logic [31:0] q, output logic v);
      @(negedge clk);
      app[d] = m; cs[d] = 1'b1; we[d] = w; addr[d] = a; wd[d] = data;
      @(posedge clk); #1;
      r = rdy[d]; q = rd[d]; v = av[d];
      @(negedge clk);
      cs[d] = 1'b0; we[d] = 4'h0;
   endtask

   // Counts cycles until busy falls; optionally pulses zeroize after 'poke' cycles.
   task automatic count_busy(input int d, input int poke, output int n);
      n = 0;
      while (bsy[d] === 1'b1 && n < 5000) begin
         @(posedge clk); #1;
         n++;
         zer[d] = (n == poke);
      end
      zer[d] = 1'b0;
   endtask

   task automatic test_reset(input int d);
      logic r, v; logic [31:0] q; int n;
      @(negedge clk); rst[d] = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({bsy[d], rdy[d], av[d], rd[d]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL reset_values d%0d: busy/ready/viol/data got %b%b%b %h want 100 0", d, bsy[d], rdy[d], av[d], rd[d]);
      end
      @(negedge clk); rst[d] = 1'b0;
      count_busy(d, -1, n);
      n_cmp++;
      if (n != (1 << baw(d))) begin
         n_bad++; $display("FAIL reset_sweep_len d%0d: got %0d want %0d", d, n, 1 << baw(d));
      end
      mdl_clear(d);
      do_access(d, 4'h0, 10'(asz(d) - 1), 32'h0, 1'b0, r, q, v);
      n_cmp++;
      if ({r, v, q} !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++; $display("FAIL read_after_clear d%0d: got r=%b v=%b %h want r=1 v=0 0", d, r, v, q);
      end
      // reset in the middle of a sweep restarts it from the beginning
      @(negedge clk); rst[d] = 1'b1;
      @(negedge clk); rst[d] = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk); rst[d] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); rst[d] = 1'b0;
      count_busy(d, -1, n);
      n_cmp++;
      if (n != (1 << baw(d))) begin
         n_bad++; $display("FAIL mid_sweep_reset d%0d: got %0d want %0d", d, n, 1 << baw(d));
      end
   endtask

   task automatic test_write_merge(input int d);
      logic r, v; logic [31:0] q; logic [9:0] a, b;
      a = 10'(10'h155 & (asz(d) - 1));
      do_access(d, 4'hF, a, 32'hDEADBEEF, 1'b0, r, q, v);
      n_cmp++;
      if ({r, v, q} !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++; $display("FAIL write_resp d%0d: got r=%b v=%b %h want r=1 v=0 0", d, r, v, q);
      end
      mdl_write(d, a, 4'hF, 32'hDEADBEEF);
      do_access(d, 4'b0010, a, 32'h0000AA00, 1'b0, r, q, v);
      mdl_write(d, a, 4'b0010, 32'h0000AA00);
      do_access(d, 4'h0, a, 32'h0, 1'b0, r, q, v);
      n_cmp++;
      if ({r, q} !== {1'b1, 32'hDEADAAEF}) begin
         n_bad++; $display("FAIL byte_merge d%0d: got r=%b %h want r=1 deadaaef", d, r, q);
      end
      for (int k = 1; k <= 2; k++) begin
         b = 10'((a ^ (k << baw(d))) & (asz(d) - 1));
         do_access(d, 4'h0, b, 32'h0, 1'b0, r, q, v);
         n_cmp++;
         if ({r, q} !== {1'b1, mdl[d][b]}) begin
            n_bad++; $display("FAIL bank_alias d%0d @%h: got %h want %h", d, b, q, mdl[d][b]);
         end
      end
   endtask

   task automatic test_boundary(input int d);
      logic r, v; logic [31:0] q; logic [9:0] al [4];
      al[0] = 10'((1 << baw(d)) - 1);
      al[1] = 10'((1 << baw(d)) & (asz(d) - 1));
      al[2] = 10'(asz(d) - 1);
      al[3] = 10'h0;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] data;
         data = $urandom();
         do_access(d, 4'hF, al[i], data, 1'b0, r, q, v);
         mdl_write(d, al[i], 4'hF, data);
      end
      for (int i = 0; i < 4; i++) begin
         do_access(d, 4'h0, al[i], 32'h0, 1'b0, r, q, v);
         n_cmp++;
         if ({r, q} !== {1'b1, mdl[d][al[i]]}) begin
            n_bad++; $display("FAIL boundary d%0d @%h: got r=%b %h want r=1 %h", d, al[i], r, q, mdl[d][al[i]]);
         end
      end
   endtask

   task automatic test_random(input int d, input int n_ops);
      logic r, v, m; logic [31:0] q, data, exp; logic [3:0] w; logic [9:0] a;
      for (int i = 0; i < n_ops; i++) begin
         w    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
         a    = 10'($urandom_range(0, 3) * (asz(d) / 4) + $urandom_range(0, 3));
         data = $urandom();
         m    = (d == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
         exp  = (m || w != 4'h0) ? 32'h0 : mdl[d][a];
         do_access(d, w, a, data, m, r, q, v);
         if (!m && w != 4'h0) mdl_write(d, a, w, data);
         n_cmp++;
         if ({r, v, q} !== {1'b1, m, exp}) begin
            n_bad++; $display("FAIL random d%0d op%0d we=%h @%h: got r=%b v=%b %h want r=1 v=%b %h", d, i, w, a, r, v, q, m, exp);
         end
      end
      app[d] = 1'b0;
   endtask

   task automatic test_back_to_back(input int d);
      logic [31:0] data, exp; logic [3:0] w; logic [9:0] a;
      for (int i = 0; i < 8; i++) begin
         w    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
         a    = 10'($urandom_range(0, 1) * (asz(d) / 2) + $urandom_range(0, 2));
         data = $urandom();
         exp  = (w != 4'h0) ? 32'h0 : mdl[d][a];
         @(negedge clk);
         cs[d] = 1'b1; we[d] = w; addr[d] = a; wd[d] = data;
         @(posedge clk); #1;
         if (w != 4'h0) mdl_write(d, a, w, data);
         n_cmp++;
         if ({rdy[d], av[d], rd[d]} !== {1'b1, 1'b0, exp}) begin
            n_bad++; $display("FAIL back_to_back d%0d op%0d: got r=%b v=%b %h want r=1 v=0 %h", d, i, rdy[d], av[d], rd[d], exp);
         end
      end
      @(negedge clk); cs[d] = 1'b0; we[d] = 4'h0;
      @(posedge clk); #1;
      n_cmp++;
      if ({rdy[d], rd[d]} !== {1'b0, 32'h0}) begin
         n_bad++; $display("FAIL idle_after_burst d%0d: got r=%b %h want r=0 0", d, rdy[d], rd[d]);
      end
   endtask

   task automatic test_lock();
      logic r, v; logic [31:0] q;
      do_access(1, 4'hF, 10'h155, 32'hDEADAAEF, 1'b0, r, q, v);
      mdl_write(1, 10'h155, 4'hF, 32'hDEADAAEF);
      do_access(1, 4'h0, 10'h155, 32'h0, 1'b1, r, q, v);
      n_cmp++;
      if ({r, v, q} !== {1'b1, 1'b1, 32'h0}) begin
         n_bad++; $display("FAIL locked_read: got r=%b v=%b %h want r=1 v=1 0", r, v, q);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (av[1] !== 1'b0) begin
         n_bad++; $display("FAIL violation_pulse: got %b want 0", av[1]);
      end
      do_access(1, 4'hF, 10'h155, 32'h12345678, 1'b1, r, q, v);
      n_cmp++;
      if ({r, v, q} !== {1'b1, 1'b1, 32'h0}) begin
         n_bad++; $display("FAIL locked_write: got r=%b v=%b %h want r=1 v=1 0", r, v, q);
      end
      do_access(1, 4'h0, 10'h155, 32'h0, 1'b0, r, q, v);
      n_cmp++;
      if ({r, q} !== {1'b1, 32'hDEADAAEF}) begin
         n_bad++; $display("FAIL unlock_read: got r=%b %h want r=1 deadaaef", r, q);
      end
   endtask

   task automatic test_app_clear(input int d);
      logic r, v; logic [31:0] q; logic [9:0] a; int n;
      a = 10'(10'h155 & (asz(d) - 1));
      do_access(d, 4'hF, a, $urandom() | 32'h1, 1'b0, r, q, v);
      @(negedge clk); app[d] = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bsy[d] !== 1'b1) begin
         n_bad++; $display("FAIL app_edge_busy d%0d: got %b want 1", d, bsy[d]);
      end
      count_busy(d, -1, n);
      mdl_clear(d);
      n_cmp++;
      if (n != (1 << baw(d))) begin
         n_bad++; $display("FAIL app_sweep_len d%0d: got %0d want %0d", d, n, 1 << baw(d));
      end
      do_access(d, 4'h0, a, 32'h0, 1'b0, r, q, v);
      n_cmp++;
      if ({r, v, q} !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++; $display("FAIL app_clear_read d%0d: got r=%b v=%b %h want r=1 v=0 0", d, r, v, q);
      end
   endtask

   task automatic test_zeroize(input int d);
      logic r, v; logic [31:0] q; logic [9:0] a; int n;
      a = 10'(asz(d) - 1);
      do_access(d, 4'hF, a, $urandom() | 32'h1, 1'b0, r, q, v);
      @(negedge clk);
      zer[d] = 1'b1; cs[d] = 1'b1; we[d] = 4'h0; addr[d] = a;
      @(posedge clk); #1;
      zer[d] = 1'b0;
      n_cmp++;
      if ({rdy[d], bsy[d]} !== 2'b01) begin
         n_bad++; $display("FAIL zeroize_priority d%0d: got ready=%b busy=%b want 0 1", d, rdy[d], bsy[d]);
      end
      // a second zeroize mid-sweep must not extend the sweep
      count_busy(d, 100, n);
      mdl_clear(d);
      n_cmp++;
      if ({n, rdy[d]} !== {1 << baw(d), 1'b0}) begin
         n_bad++; $display("FAIL zeroize_sweep d%0d: got len=%0d ready=%b want %0d 0", d, n, rdy[d], 1 << baw(d));
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({rdy[d], rd[d]} !== {1'b1, mdl[d][a]}) begin
         n_bad++; $display("FAIL held_cs_after_clear d%0d: got r=%b %h want r=1 %h", d, rdy[d], rd[d], mdl[d][a]);
      end
      @(negedge clk); cs[d] = 1'b0;
   endtask

   initial begin
      rst = '1; app = '0; zer = '0; cs = '0; we = '0; addr = '0; wd = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = '0;
      for (int d = 0; d < ND; d++) test_reset(d);
      for (int d = 0; d < ND; d++) begin
         test_write_merge(d);
         test_boundary(d);
         test_back_to_back(d);
         test_random(d, 40);
      end
      test_lock();
      test_app_clear(0);
      test_app_clear(2);
      test_app_clear(3);
      for (int d = 0; d < ND; d++) test_zeroize(d);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
